temperature_sampler: RTL
========================

// Module: temperature_sampler
// PURPOSE
//  Upstream feeder of the dest/curr display stage: drives an 8-bit serial ADC (TLC549-style),
//  averages 2^AVG_LOG2 conversions, publishes the scaled temperature code `curr` (0..255).
//  Free-running while `enable` is high. `curr` goes unchanged into the display stage and controller.
// PARAMETERS
//  CLK_DIV    25    system clocks per adcClk half-period (legal range 4..255)
//  CONV_WAIT  1000  system clocks with adcCs high between frames, covering ADC conversion (>=17 us)
//  AVG_LOG2   3     log2 of the number of samples averaged per output (legal range 1..4)
// PORTS
//  clock      in   1  system clock; all logic on posedge
//  resetN     in   1  asynchronous, active-low reset
//  enable     in   1  1 = run frames; 0 = finish the current frame, then idle with adcCs high
//  adcData    in   1  ADC serial data, MSB first; asynchronous to clock
//  adcCs      out  1  ADC chip select, active low
//  adcClk     out  1  ADC I/O clock
//  curr       out  8  averaged temperature code
//  currValid  out  1  one-cycle pulse in the same cycle `curr` updates
//  sensorFault out 1  present only with TEMP_SAMPLER_FAULT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): adcCs=1, adcClk=0, curr=0, currValid=0,
//   sensorFault=0, accumulator=0, sample count=0, state=WAIT, timer=0.
//  Reset mid-frame: abort immediately with the values above. A partial frame is discarded.
//  adcData passes through a 2-flop synchronizer before use. Sample timing below is post-sync.
//  FSM states:
//   WAIT   adcCs=1. Count CONV_WAIT clocks, then go to SETUP if enable=1, else stay in WAIT.
//   SETUP  adcCs=0, adcClk=0 for CLK_DIV+2 clocks (sync latency), then go to SHIFT.
//   SHIFT  8 I/O periods: adcClk low CLK_DIV clocks, then high CLK_DIV clocks.
//          Bit k (MSB first) is shifted in on the last clock of the k-th low half.
//          After the 8th high half: adcClk=0, go to ACCUM.
//   ACCUM  1 clock, adcCs=1: sum += sample, count += 1.
//          If count reaches 2^AVG_LOG2: curr <= (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2 and
//          currValid=1 for this cycle; sum and count are cleared. Then go to WAIT.
//  Width: sum is 8+AVG_LOG2 bits. The rounded result is at most 255, so no saturation is needed.
//  enable falling mid-frame: the frame completes and its sample is accumulated.
//   The FSM then holds in WAIT. The partial average is kept, not cleared.
//  Frame period = CONV_WAIT + CLK_DIV+2 + 16*CLK_DIV + 1 clocks.
//  Output latency = 2^AVG_LOG2 frame periods.
//  First frame after reset starts only after a full CONV_WAIT, so the ADC's power-on
//   conversion is discarded.
//  adcCs and adcClk are registered outputs (glitch-free) and never change in the same cycle.
// CONFIGURATION
//  TEMP_SAMPLER_FAULT_EN defined:
//   - A raw sample of 8'h00 or 8'hFF is a fault: it is not accumulated and count is unchanged.
//   - sensorFault is set in that ACCUM cycle.
//   - sensorFault clears on the next valid sample; `curr` holds its last value meanwhile.
//  TEMP_SAMPLER_FAULT_EN undefined:
//   - The sensorFault port is absent.
//   - Every sample is accumulated.
// STRUCTURE
//  temperature_defs.vh (shared header): FSM state encodings (WAIT/SETUP/SHIFT/ACCUM),
//   fault codes 8'h00/8'hFF, default CLK_DIV/CONV_WAIT values.
//   The controller and display stage include the same header.
//  One sub-module, tlc549_reader:
//   - Contains the synchronizer, SETUP/SHIFT timing and shift register.
//   - Handshake: start in, sample[7:0]/done out; done is a 1-clock pulse.
//   - temperature_sampler keeps the WAIT timer, enable gating, accumulator and fault logic.
// TESTING  (bench ADC model: presents MSB when adcCs falls, next bit on each adcClk fall)
//  Constant 8'h80, AVG_LOG2=3 -> after 8 frames curr=8'h80, exactly one currValid pulse.
//  Samples 10,10,10,10,11,11,11,11 -> sum 84, (84+4)>>3 = 11 -> curr=8'h0B (rounding up).
//  All samples 8'hFF without FAULT_EN -> curr=8'hFF, no overflow.
//   With FAULT_EN -> curr stays 0, sensorFault=1.
//  enable dropped mid-SHIFT -> full 8 adcClk periods still occur, then adcCs stays 1.
//   Re-enable: count resumes from the held value.
//  resetN pulsed low during SHIFT -> same cycle adcCs=1, adcClk=0, curr=0.
//   First new adcCs fall comes CONV_WAIT clocks after release.
//  Timing check with CLK_DIV=4: adcClk high and low halves are each 4 clocks.
//   adcCs-low to first adcClk rise is >= 10 clocks.

Source files
------------

// File: rtl/temperature_sampler_pkg.sv
// Shared definitions for the temperature sampler and its TLC549 reader:
// default timing parameters, ADC fault codes and FSM state types.
package temperature_sampler_pkg;

  localparam int unsigned DEF_CLK_DIV   = 25;
  localparam int unsigned DEF_CONV_WAIT = 1000;
  localparam int unsigned DEF_AVG_LOG2  = 3;

  // Rail values returned by an open or shorted sensor.
  localparam logic [7:0] FAULT_CODE_LO = 8'h00;
  localparam logic [7:0] FAULT_CODE_HI = 8'hFF;

  // Sampler sequencing; READ covers the reader's SETUP and SHIFT phases.
  typedef enum logic [1:0] {
    SMP_WAIT,
    SMP_READ,
    SMP_ACCUM
  } smp_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SETUP,
    RD_SHIFT
  } rd_state_e;

  function automatic logic is_fault_code(input logic [7:0] s);
    return (s == FAULT_CODE_LO) || (s == FAULT_CODE_HI);
  endfunction

endpackage

// File: rtl/temperature_sampler_tlc549_reader.sv
// tlc549_reader: one serial read of an 8-bit TLC549-style ADC.
// A start pulse runs SETUP (adcCs low, CLK_DIV+2 clocks) then SHIFT
// (8 I/O periods, CLK_DIV clocks per half). Data is synchronized by two
// flops and shifted in MSB first on the last clock of each low half.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   start_i     begin a frame (honoured only when idle)
//   adc_data_i  ADC serial data, asynchronous
//   adc_cs_o    registered chip select, active low
//   adc_clk_o   registered ADC I/O clock
//   sample_o    last assembled sample
//   done_o      1-clock pulse in the final SHIFT clock; sample_o is valid
module tlc549_reader
  import temperature_sampler_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       adc_data_i,
  output logic       adc_cs_o,
  output logic       adc_clk_o,
  output logic [7:0] sample_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 2);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       half_q, half_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sync1_q, sync2_q;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          state_d = RD_SETUP;
          cnt_d   = '0;
        end
      end
      RD_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV + 1)) begin
          state_d = RD_SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!half_q[0]) begin
            shreg_d = {shreg_q[6:0], sync2_q};
          end
          if (half_q == 4'd15) begin
            state_d = RD_IDLE;
          end else begin
            half_d = half_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if ((half_q == 4'd15) && (cnt_q == CNT_W'(CLK_DIV - 2))) begin
          done_d = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Outputs are registered from the next state. adcCs rises one clock after
  // the final adcClk fall so the two pins never toggle on the same edge.
  always_comb begin
    sclk_d = (state_d == RD_SHIFT) && half_d[0];
    cs_d   = (state_d == RD_IDLE) && (state_q != RD_SHIFT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      shreg_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      sync1_q <= adc_data_i;
      sync2_q <= sync1_q;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  assign adc_cs_o  = cs_q;
  assign adc_clk_o = sclk_q;
  assign sample_o  = shreg_q;
  assign done_o    = done_q;

endmodule

// File: rtl/temperature_sampler.sv
// temperature_sampler: free-running ADC sampler that averages 2^AVG_LOG2
// conversions (rounded) into the temperature code `curr`.
// Optional feature macro: TEMP_SAMPLER_FAULT_EN (rail samples rejected,
// sensorFault output present).
// Ports:
//   clock        system clock
//   resetN       asynchronous active-low reset
//   enable       run frames; when low the current frame completes, then idle
//   adcData      ADC serial data
//   adcCs        ADC chip select, active low
//   adcClk       ADC I/O clock
//   curr         averaged temperature code
//   currValid    1-cycle pulse when curr updates
//   sensorFault  last sample was a rail value (TEMP_SAMPLER_FAULT_EN only)
module temperature_sampler
  import temperature_sampler_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned CONV_WAIT = DEF_CONV_WAIT,
  parameter int unsigned AVG_LOG2  = DEF_AVG_LOG2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       enable,
  input  logic       adcData,
  output logic       adcCs,
  output logic       adcClk,
  output logic [7:0] curr,
  output logic       currValid
`ifdef TEMP_SAMPLER_FAULT_EN
  ,
  output logic       sensorFault
`endif
);

  localparam int unsigned TMR_W = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;
  localparam int unsigned SUM_W = 8 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] NSAMP     = CNT_W'(2 ** AVG_LOG2);
  localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(2 ** (AVG_LOG2 - 1));

  smp_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SUM_W-1:0] sum_q, sum_d, sum_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
  logic [7:0]       curr_q, curr_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             rd_start, rd_done;
  logic [7:0]       rd_sample;
`ifdef TEMP_SAMPLER_FAULT_EN
  logic             fault_q, fault_d;
`endif

  tlc549_reader #(
    .CLK_DIV(CLK_DIV)
  ) u_reader (
    .clk_i     (clock),
    .rst_ni    (resetN),
    .start_i   (rd_start),
    .adc_data_i(adcData),
    .adc_cs_o  (adcCs),
    .adc_clk_o (adcClk),
    .sample_o  (rd_sample),
    .done_o    (rd_done)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    curr_d   = curr_q;
    valid_d  = 1'b0;
    rd_start = 1'b0;
    accept   = 1'b0;
`ifdef TEMP_SAMPLER_FAULT_EN
    fault_d  = fault_q;
`endif
    sum_acc  = sum_q + SUM_W'(rd_sample);
    cnt_acc  = cnt_q + CNT_W'(1);
    unique case (state_q)
      SMP_WAIT: begin
        // Timer saturates at the end of the wait so a late enable starts at once.
        if (timer_q == TMR_W'(CONV_WAIT - 1)) begin
          if (enable) begin
            rd_start = 1'b1;
            state_d  = SMP_READ;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SMP_READ: begin
        if (rd_done) state_d = SMP_ACCUM;
      end
      SMP_ACCUM: begin
        state_d = SMP_WAIT;
        timer_d = '0;
`ifdef TEMP_SAMPLER_FAULT_EN
        accept  = !is_fault_code(rd_sample);
        fault_d = !accept;
`else
        accept  = 1'b1;
`endif
        if (accept) begin
          if (cnt_acc == NSAMP) begin
            // Rounded mean never exceeds 255, so truncation is exact.
            curr_d  = 8'((sum_acc + ROUND_ADD) >> AVG_LOG2);
            valid_d = 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
          end else begin
            sum_d = sum_acc;
            cnt_d = cnt_acc;
          end
        end
      end
      default: state_d = SMP_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= SMP_WAIT;
      timer_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      curr_q  <= '0;
      valid_q <= 1'b0;
`ifdef TEMP_SAMPLER_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      curr_q  <= curr_d;
      valid_q <= valid_d;
`ifdef TEMP_SAMPLER_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign curr      = curr_q;
  assign currValid = valid_q;
`ifdef TEMP_SAMPLER_FAULT_EN
  assign sensorFault = fault_q;
`endif

endmodule
